// File: rtl/frv_pipeline_writeback_pkg.sv
// Shared encodings for the writeback stage: functional units, LSU micro-op bits,
// wide-op codes, trap causes, FSM states and the registered control payload.
package frv_pipeline_writeback_pkg;

   localparam int unsigned OP = 4;
   localparam int unsigned FU = 7;

   localparam int unsigned P_FU_ALU = 0;
   localparam int unsigned P_FU_MUL = 1;
   localparam int unsigned P_FU_LSU = 2;
   localparam int unsigned P_FU_CFU = 3;
   localparam int unsigned P_FU_CSR = 4;
   localparam int unsigned P_FU_ASI = 5;
   localparam int unsigned P_FU_BIT = 6;
   localparam int unsigned P_FU_RNG = 7;

   localparam int unsigned LSU_SIGNED   = 0;
   localparam int unsigned LSU_LOAD     = 1;
   localparam int unsigned LSU_STORE    = 2;
   localparam int unsigned LSU_MMIO_BIT = 4;

   localparam logic [1:0] LSU_BYTE = 2'b01;
   localparam logic [1:0] LSU_HALF = 2'b10;
   localparam logic [1:0] LSU_WORD = 2'b11;

   localparam logic [OP:0] BIT_RORW = 5'd8;
   localparam logic [OP:0] MUL_MADD = 5'd12;
   localparam logic [OP:0] MUL_MSUB = 5'd13;
   localparam logic [OP:0] MUL_MACC = 5'd14;
   localparam logic [OP:0] MUL_MMUL = 5'd15;

   localparam logic [5:0] TRAP_LDACCESS = 6'd5;
   localparam logic [5:0] TRAP_STACCESS = 6'd7;

   typedef enum logic [0:0] {
      WB_IDLE = 1'b0,
      WB_WAIT = 1'b1
   } wb_state_t;

   typedef struct packed {
      logic       trap;
      logic [5:0] cause;
      logic       retire;
      logic       wen;
      logic       wide;
      logic [4:0] rd;
   } wb_ctl_t;

   // Ops whose result spans two registers (hi half carried on opr_b).
   function automatic logic is_wide_op(input logic [FU:0] fu, input logic [OP:0] uop);
      return (fu[P_FU_MUL] && (uop == MUL_MADD || uop == MUL_MSUB ||
                               uop == MUL_MACC || uop == MUL_MMUL)) ||
             (fu[P_FU_BIT] && uop == BIT_RORW);
   endfunction

endpackage

// File: rtl/frv_pipeline_writeback_load_format.sv
// Aligns and extends load data: byte/half selected by the low address bits.
module frv_load_format
   import frv_pipeline_writeback_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr,
   input  logic [1:0]      size,
   input  logic            sext,
   output logic [XLEN-1:0] data_c
);

   logic [XLEN-1:0] byte_sh;
   logic [XLEN-1:0] half_sh;

   always_comb begin
      byte_sh = rdata >> {addr, 3'b000};
      half_sh = rdata >> {addr[1], 4'b0000};
      data_c  = rdata;
      case (size)
         LSU_BYTE: data_c = {{(XLEN-8){sext & byte_sh[7]}}, byte_sh[7:0]};
         LSU_HALF: data_c = {{(XLEN-16){sext & half_sh[15]}}, half_sh[15:0]};
         default:  data_c = rdata;
      endcase
   end

endmodule

// File: rtl/frv_pipeline_writeback.sv
// Pipeline stage 4: completes instructions, waits for/buffers memory responses,
// and produces one-cycle register-file write, retire and trap pulses.
module frv_pipeline_writeback
   import frv_pipeline_writeback_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            flush,
   input  logic [4:0]      s4_rd,
   input  logic [XLEN-1:0] s4_opr_a,
   input  logic [XLEN-1:0] s4_opr_b,
   input  logic [OP:0]     s4_uop,
   input  logic [FU:0]     s4_fu,
   input  logic            s4_trap,
   input  logic [1:0]      s4_size,
   input  logic [31:0]     s4_instr,
   input  logic            s4_valid,
   output logic            s4_busy,
   input  logic            dmem_recv,
   input  logic            dmem_error,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic [XLEN-1:0] mmio_rdata,
   input  logic            mmio_error,
   output logic            hold_lsu_req,
   output logic            gpr_wen,
   output logic            gpr_wide,
   output logic [4:0]      gpr_rd,
   output logic [XLEN-1:0] gpr_wdata,
   output logic [XLEN-1:0] gpr_wdata_hi,
   output logic            trap_raise,
   output logic [5:0]      trap_cause,
   output logic            retire
);

   wb_state_t       state_q, state_d;
   logic            buf_valid_q, buf_valid_d;
   logic            buf_err_q, buf_err_d;
   logic [XLEN-1:0] buf_data_q, buf_data_d;
   logic            drop_pend_q, drop_pend_d;
   logic            rsp_ovf_q, rsp_ovf_d;
   wb_ctl_t         ctl_q, ctl_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] wdata_hi_q, wdata_hi_d;

   logic            fu_lsu, mmio, lsu_mem, complete, fire;
   logic            use_buf, take_recv, unsolicited;
   logic            rsp_err;
   logic [XLEN-1:0] rsp_data, load_data;

   assign fu_lsu      = s4_fu[P_FU_LSU];
   assign mmio        = s4_opr_a[LSU_MMIO_BIT];
   assign lsu_mem     = s4_valid && fu_lsu && !s4_trap && !mmio;
   assign complete    = s4_valid && (s4_trap || !fu_lsu || mmio || dmem_recv || buf_valid_q);
   assign fire        = complete && !flush;
   assign use_buf     = lsu_mem && buf_valid_q;
   assign take_recv   = lsu_mem && !buf_valid_q && dmem_recv;
   assign unsolicited = dmem_recv && !take_recv;

   // The buffered response always predates a live one, so it is served first.
   assign rsp_data = mmio ? mmio_rdata : (buf_valid_q ? buf_data_q : dmem_rdata);
   assign rsp_err  = mmio ? mmio_error : (buf_valid_q ? buf_err_q  : dmem_error);

   assign s4_busy      = s4_valid && !complete;
   assign hold_lsu_req = buf_valid_q || (state_q == WB_WAIT);

   frv_load_format #(.XLEN(XLEN)) u_fmt (
      .rdata  (rsp_data),
      .addr   (s4_opr_b[1:0]),
      .size   (s4_size),
      .sext   (s4_uop[LSU_SIGNED]),
      .data_c (load_data)
   );

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) state_q <= WB_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      buf_valid_d = buf_valid_q;
      buf_err_d   = buf_err_q;
      buf_data_d  = buf_data_q;
      drop_pend_d = drop_pend_q;
      rsp_ovf_d   = rsp_ovf_q;
      ctl_d       = '0;
      wdata_d     = '0;
      wdata_hi_d  = '0;

      case (state_q)
         WB_IDLE: if (lsu_mem && !buf_valid_q && !dmem_recv && !flush) state_d = WB_WAIT;
         WB_WAIT: if (dmem_recv || flush)                              state_d = WB_IDLE;
         default: state_d = WB_IDLE;
      endcase

      if (use_buf) buf_valid_d = 1'b0;

      // Responses nobody is waiting for: discard if owed to a flushed op, else buffer.
      if (unsolicited) begin
         if (drop_pend_q) begin
            drop_pend_d = 1'b0;
         end else if (buf_valid_q && !use_buf) begin
            rsp_ovf_d = 1'b1;
         end else begin
            buf_valid_d = 1'b1;
            buf_err_d   = dmem_error;
            buf_data_d  = dmem_rdata;
         end
      end

      if (flush) begin
         buf_valid_d = 1'b0;
         if (state_q == WB_WAIT && !dmem_recv) drop_pend_d = 1'b1;
      end

      if (fire) begin
         if (s4_trap) begin
            ctl_d.trap  = 1'b1;
            ctl_d.cause = {1'b0, s4_rd};
         end else if (fu_lsu && rsp_err) begin
            ctl_d.trap  = 1'b1;
            ctl_d.cause = s4_uop[LSU_LOAD] ? TRAP_LDACCESS : TRAP_STACCESS;
         end else begin
            ctl_d.retire = 1'b1;
            if ((!fu_lsu || s4_uop[LSU_LOAD]) && s4_rd != 5'd0) begin
               ctl_d.wen = 1'b1;
               ctl_d.rd  = s4_rd;
               wdata_d   = fu_lsu ? load_data : s4_opr_a;
               if (!fu_lsu && is_wide_op(s4_fu, s4_uop)) begin
                  ctl_d.wide = 1'b1;
                  wdata_hi_d = s4_opr_b;
               end
            end
         end
      end
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         buf_valid_q <= 1'b0;
         buf_err_q   <= 1'b0;
         buf_data_q  <= '0;
         drop_pend_q <= 1'b0;
         rsp_ovf_q   <= 1'b0;
         ctl_q       <= '0;
         wdata_q     <= '0;
         wdata_hi_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_err_q   <= buf_err_d;
         buf_data_q  <= buf_data_d;
         drop_pend_q <= drop_pend_d;
         rsp_ovf_q   <= rsp_ovf_d;
         ctl_q       <= ctl_d;
         wdata_q     <= wdata_d;
         wdata_hi_q  <= wdata_hi_d;
      end
   end

   assign gpr_wen      = ctl_q.wen;
   assign gpr_wide     = ctl_q.wide;
   assign gpr_rd       = ctl_q.rd;
   assign gpr_wdata    = wdata_q;
   assign gpr_wdata_hi = wdata_hi_q;
   assign trap_raise   = ctl_q.trap;
   assign trap_cause   = ctl_q.cause;
   assign retire       = ctl_q.retire;

   // Instruction word, other unit selects and the overflow flag are debug-only here.
   logic unused_sigs;
   assign unused_sigs = ^{s4_instr, s4_fu, rsp_ovf_q, s4_uop[LSU_STORE]};

endmodule

// File: tb/tb_frv_pipeline_writeback.sv
// Scoreboard bench for the writeback stage: expected pulses are queued at drive
// time and matched (content and cycle) when the stage emits them.
module tb_frv_pipeline_writeback;
   import frv_pipeline_writeback_pkg::*;

   localparam logic [7:0] F_ALU = 8'h01;
   localparam logic [7:0] F_MUL = 8'h02;
   localparam logic [7:0] F_LSU = 8'h04;
   localparam logic [7:0] F_BIT = 8'h40;
   localparam logic [4:0] U_LD  = 5'b00010;
   localparam logic [4:0] U_LDS = 5'b00011;
   localparam logic [4:0] U_ST  = 5'b00100;

   logic        g_clk = 1'b0, g_resetn = 1'b0, flush = 1'b0;
   logic [4:0]  s4_rd = '0;
   logic [31:0] s4_opr_a = '0, s4_opr_b = '0, s4_instr = '0;
   logic [4:0]  s4_uop = '0;
   logic [7:0]  s4_fu = '0;
   logic        s4_trap = 1'b0, s4_valid = 1'b0;
   logic [1:0]  s4_size = '0;
   logic        s4_busy, hold_lsu_req;
   logic        dmem_recv = 1'b0, dmem_error = 1'b0, mmio_error = 1'b0;
   logic [31:0] dmem_rdata = '0, mmio_rdata = '0;
   logic        gpr_wen, gpr_wide, trap_raise, retire;
   logic [4:0]  gpr_rd;
   logic [31:0] gpr_wdata, gpr_wdata_hi;
   logic [5:0]  trap_cause;

   typedef struct {
      logic        trap;
      logic [5:0]  cause;
      logic        ret;
      logic        wen;
      logic        wide;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [31:0] hi;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   frv_pipeline_writeback #(.XLEN(32)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
      .s4_rd(s4_rd), .s4_opr_a(s4_opr_a), .s4_opr_b(s4_opr_b), .s4_uop(s4_uop),
      .s4_fu(s4_fu), .s4_trap(s4_trap), .s4_size(s4_size), .s4_instr(s4_instr),
      .s4_valid(s4_valid), .s4_busy(s4_busy),
      .dmem_recv(dmem_recv), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
      .mmio_rdata(mmio_rdata), .mmio_error(mmio_error), .hold_lsu_req(hold_lsu_req),
      .gpr_wen(gpr_wen), .gpr_wide(gpr_wide), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata),
      .gpr_wdata_hi(gpr_wdata_hi), .trap_raise(trap_raise), .trap_cause(trap_cause),
      .retire(retire)
   );

   always #5 g_clk = ~g_clk;
   always @(posedge g_clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic idle_in();
      s4_valid = 1'b0; s4_trap = 1'b0; flush = 1'b0;
      s4_fu = '0; s4_uop = '0; s4_rd = '0; s4_opr_a = '0; s4_opr_b = '0;
      dmem_recv = 1'b0; dmem_error = 1'b0; mmio_error = 1'b0; mmio_rdata = '0;
   endtask

   task automatic drive(input logic [7:0] fu, input logic [4:0] uop, input logic [1:0] size,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic trap);
      s4_valid = 1'b1; s4_fu = fu; s4_uop = uop; s4_size = size; s4_rd = rd;
      s4_opr_a = a; s4_opr_b = b; s4_trap = trap; s4_instr = $urandom();
   endtask

   task automatic recv(input logic [31:0] data, input logic err);
      dmem_recv = 1'b1; dmem_rdata = data; dmem_error = err;
   endtask

   // Pulse expected at the edge that ends the current cycle.
   task automatic expect_wb(input logic trap, input logic [5:0] cause, input logic ret,
                            input logic wen, input logic wide, input logic [4:0] rd,
                            input logic [31:0] wd, input logic [31:0] hi);
      exp_t e;
      e.trap = trap; e.cause = cause; e.ret = ret; e.wen = wen; e.wide = wide;
      e.rd = rd; e.wd = wd; e.hi = hi; e.cyc = cyc + 1;
      sb.push_back(e);
   endtask

   always @(negedge g_clk) begin
      exp_t e;
      if (g_resetn) begin
         if (trap_raise || retire || gpr_wen || gpr_wide) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_pulse", 64'({trap_raise, retire, gpr_wen, gpr_wide}), 64'd0);
            end else begin
               e = sb.pop_front();
               check_eq("pulse_cycle", 64'(cyc), 64'(e.cyc));
               check_eq("trap_raise", 64'(trap_raise), 64'(e.trap));
               check_eq("trap_cause", 64'(trap_cause), 64'(e.cause));
               check_eq("retire", 64'(retire), 64'(e.ret));
               check_eq("gpr_wen", 64'(gpr_wen), 64'(e.wen));
               check_eq("gpr_wide", 64'(gpr_wide), 64'(e.wide));
               check_eq("gpr_rd", 64'(gpr_rd), 64'(e.rd));
               check_eq("gpr_wdata", 64'(gpr_wdata), 64'(e.wd));
               check_eq("gpr_wdata_hi", 64'(gpr_wdata_hi), 64'(e.hi));
            end
         end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check_eq("missing_pulse", 64'(cyc), 64'(e.cyc + 1000));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      idle_in();
      repeat (3) @(posedge g_clk);
      @(negedge g_clk);
      check_eq("rst_gpr_wen", 64'(gpr_wen), 64'd0);
      check_eq("rst_retire", 64'(retire), 64'd0);
      check_eq("rst_trap", 64'(trap_raise), 64'd0);
      check_eq("rst_wdata", 64'(gpr_wdata), 64'd0);
      check_eq("rst_hold", 64'(hold_lsu_req), 64'd0);
      check_eq("rst_busy", 64'(s4_busy), 64'd0);
      @(posedge g_clk); #1;
      g_resetn = 1'b1;
      step();

      // LBU at 0x1003, response two cycles later
      drive(F_LSU, U_LD, LSU_BYTE, 5'd5, 32'h1, 32'h1003, 1'b0); #1;
      check_eq("lbu_busy0", 64'(s4_busy), 64'd1);
      step();
      check_eq("lbu_busy1", 64'(s4_busy), 64'd1);
      check_eq("lbu_hold", 64'(hold_lsu_req), 64'd1);
      recv(32'h80AA_BBCC, 1'b0);
      expect_wb(0, 6'd0, 1, 1, 0, 5'd5, 32'h0000_0080, 32'h0); #1;
      check_eq("lbu_busy2", 64'(s4_busy), 64'd0);
      step(); idle_in(); #1;
      check_eq("lbu_hold_after", 64'(hold_lsu_req), 64'd0);
      step();

      // LH signed at 0x2002
      drive(F_LSU, U_LDS, LSU_HALF, 5'd6, 32'h3, 32'h2002, 1'b0);
      recv(32'h8001_1234, 1'b0);
      expect_wb(0, 6'd0, 1, 1, 0, 5'd6, 32'hFFFF_8001, 32'h0);
      step(); idle_in();

      // SW with bus error
      drive(F_LSU, U_ST, LSU_WORD, 5'd0, 32'hF, 32'h2004, 1'b0);
      recv(32'h0, 1'b1);
      expect_wb(1, 6'd7, 0, 0, 0, 5'd0, 32'h0, 32'h0);
      step(); idle_in();

      // MUL_MADD, wide write in the same cycle
      drive(F_MUL, MUL_MADD, LSU_WORD, 5'd4, 32'h1, 32'h2, 1'b0); #1;
      check_eq("madd_busy", 64'(s4_busy), 64'd0);
      expect_wb(0, 6'd0, 1, 1, 1, 5'd4, 32'h1, 32'h2);
      step(); idle_in();

      // BIT_RORW is also wide
      drive(F_BIT, BIT_RORW, LSU_WORD, 5'd19, 32'hAAAA_5555, 32'h0F0F_F0F0, 1'b0);
      expect_wb(0, 6'd0, 1, 1, 1, 5'd19, 32'hAAAA_5555, 32'h0F0F_F0F0);
      step(); idle_in();

      // Flush while waiting: the late response is dropped
      drive(F_LSU, U_LD, LSU_WORD, 5'd7, 32'h1, 32'h3000, 1'b0);
      step();
      check_eq("fl_hold_wait", 64'(hold_lsu_req), 64'd1);
      flush = 1'b1;
      step(); idle_in(); #1;
      check_eq("fl_hold_idle", 64'(hold_lsu_req), 64'd0);
      step();
      recv(32'hDEAD_BEEF, 1'b0);
      step(); idle_in(); #1;
      check_eq("fl_not_buffered", 64'(hold_lsu_req), 64'd0);
      drive(F_LSU, U_LD, LSU_WORD, 5'd8, 32'h1, 32'h3004, 1'b0); #1;
      check_eq("fl_next_busy", 64'(s4_busy), 64'd1);
      step();
      check_eq("fl_next_busy1", 64'(s4_busy), 64'd1);
      recv(32'h1111_2222, 1'b0);
      expect_wb(0, 6'd0, 1, 1, 0, 5'd8, 32'h1111_2222, 32'h0);
      step(); idle_in();

      // Unsolicited response buffered, consumed by the next LW
      recv(32'h1234_5678, 1'b0);
      step(); idle_in(); #1;
      check_eq("buf_hold0", 64'(hold_lsu_req), 64'd1);
      step();
      check_eq("buf_hold1", 64'(hold_lsu_req), 64'd1);
      drive(F_LSU, U_LD, LSU_WORD, 5'd9, 32'h1, 32'h4000, 1'b0); #1;
      check_eq("buf_busy", 64'(s4_busy), 64'd0);
      expect_wb(0, 6'd0, 1, 1, 0, 5'd9, 32'h1234_5678, 32'h0);
      step(); idle_in(); #1;
      check_eq("buf_hold_clr", 64'(hold_lsu_req), 64'd0);

      // Trapped instruction: cause comes from rd
      drive(F_ALU, 5'd0, LSU_WORD, 5'd3, 32'h55, 32'h0, 1'b1);
      expect_wb(1, 6'd3, 0, 0, 0, 5'd0, 32'h0, 32'h0);
      step(); idle_in();

      // ALU write to x0 retires without a write
      drive(F_ALU, 5'd0, LSU_WORD, 5'd0, 32'h77, 32'h0, 1'b0);
      expect_wb(0, 6'd0, 1, 0, 0, 5'd0, 32'h0, 32'h0);
      step(); idle_in();

      // MMIO signed byte load at offset 1
      drive(F_LSU, U_LDS, LSU_BYTE, 5'd10, 32'h12, 32'h41, 1'b0);
      mmio_rdata = 32'h0000_F700; #1;
      check_eq("mmio_busy", 64'(s4_busy), 64'd0);
      expect_wb(0, 6'd0, 1, 1, 0, 5'd10, 32'hFFFF_FFF7, 32'h0);
      step(); idle_in();

      // MMIO store error, then a load with a bus error
      drive(F_LSU, U_ST, LSU_WORD, 5'd0, 32'h1F, 32'h44, 1'b0);
      mmio_error = 1'b1;
      expect_wb(1, 6'd7, 0, 0, 0, 5'd0, 32'h0, 32'h0);
      step(); idle_in();
      drive(F_LSU, U_LD, LSU_WORD, 5'd12, 32'h1, 32'h48, 1'b0);
      recv(32'h5A5A_5A5A, 1'b1);
      expect_wb(1, 6'd5, 0, 0, 0, 5'd0, 32'h0, 32'h0);
      step(); idle_in();

      // Unsigned half at offset 0
      drive(F_LSU, U_LD, LSU_HALF, 5'd13, 32'h3, 32'h5000, 1'b0);
      recv(32'hABCD_8765, 1'b0);
      expect_wb(0, 6'd0, 1, 1, 0, 5'd13, 32'h0000_8765, 32'h0);
      step(); idle_in();

      // Flush coinciding with completion wins
      drive(F_ALU, 5'd0, LSU_WORD, 5'd14, 32'h99, 32'h0, 1'b0);
      flush = 1'b1;
      step(); idle_in();

      // Overflow: second unsolicited response is dropped
      recv(32'hAAAA_0001, 1'b0);
      step();
      recv(32'hBBBB_0002, 1'b0);
      step(); idle_in();
      drive(F_LSU, U_LD, LSU_WORD, 5'd15, 32'h1, 32'h6000, 1'b0);
      expect_wb(0, 6'd0, 1, 1, 0, 5'd15, 32'hAAAA_0001, 32'h0);
      step(); idle_in(); #1;
      check_eq("ovf_hold_clr", 64'(hold_lsu_req), 64'd0);
      drive(F_LSU, U_LD, LSU_WORD, 5'd16, 32'h1, 32'h6004, 1'b0); #1;
      check_eq("ovf_next_busy", 64'(s4_busy), 64'd1);
      step();
      recv(32'hCCCC_0003, 1'b0);
      expect_wb(0, 6'd0, 1, 1, 0, 5'd16, 32'hCCCC_0003, 32'h0);
      step(); idle_in();

      // Flush clears a buffered response
      recv(32'h0D0D_0D0D, 1'b0);
      step(); idle_in();
      flush = 1'b1;
      step(); idle_in(); #1;
      check_eq("flush_buf_clr", 64'(hold_lsu_req), 64'd0);

      // Reset while waiting: the late response becomes unsolicited
      drive(F_LSU, U_LD, LSU_WORD, 5'd17, 32'h1, 32'h7000, 1'b0);
      step();
      check_eq("rw_hold", 64'(hold_lsu_req), 64'd1);
      g_resetn = 1'b0; idle_in(); #1;
      check_eq("rw_hold_rst", 64'(hold_lsu_req), 64'd0);
      step();
      g_resetn = 1'b1;
      step();
      recv(32'hCAFE_F00D, 1'b0);
      step(); idle_in(); #1;
      check_eq("rw_buffered", 64'(hold_lsu_req), 64'd1);
      drive(F_LSU, U_LD, LSU_WORD, 5'd18, 32'h1, 32'h7004, 1'b0);
      expect_wb(0, 6'd0, 1, 1, 0, 5'd18, 32'hCAFE_F00D, 32'h0);
      step(); idle_in();

      repeat (3) step();
      check_eq("sb_drain", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
